// File: rtl/wb_stage.sv
// Writeback stage: holds the MEM/WB register, waits for load responses, extracts load data
// and drives the register file write port. Hung loads time out and raise a sticky flag.
module wb_stage #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned ADDR_WIDTH     = 5,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [ADDR_WIDTH-1:0] i_rd,
  input  logic                  i_regWrite,
  input  logic                  i_isLoad,
  input  logic [2:0]            i_funct3,
  input  logic [XLEN-1:0]       i_result,
  input  logic                  i_dmemRspValid,
  input  logic [XLEN-1:0]       i_dmemRspData,
  output logic                  o_stall,
  output logic                  o_rfWrEn,
  output logic [ADDR_WIDTH-1:0] o_rfRdAddr,
  output logic [XLEN-1:0]       o_rfRdData,
  output logic                  o_retire,
  output logic                  o_loadFault,
  output logic                  o_loadTimeout
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] KLast = CntW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e                state_q;
  logic [CntW-1:0]       k_q;
  logic                  timeout_q;
  logic                  s_v_q;
  logic [ADDR_WIDTH-1:0] s_rd_q;
  logic                  s_regwrite_q;
  logic                  s_isload_q;
  logic [2:0]            s_funct3_q;
  logic [XLEN-1:0]       s_result_q;

  // Misaligned halfword/word or a funct3 that is not a defined load type.
  function automatic logic load_bad(input logic [2:0] f3, input logic [1:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = (off != 2'b00);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  logic            in_wait;
  logic            k_last;
  logic            rsp_take;
  logic            timeout_hit;
  logic            stall;
  logic            s_fault;
  logic            rd_nonzero;
  logic [1:0]      off;
  logic [XLEN-1:0] byte_word;
  logic [XLEN-1:0] half_word;
  logic [XLEN-1:0] load_data;

  always_comb begin
    in_wait     = (state_q == StWait);
    k_last      = (k_q == KLast);
    rsp_take    = in_wait && i_dmemRspValid;
    timeout_hit = in_wait && !i_dmemRspValid && k_last;
    stall       = in_wait && !i_dmemRspValid && !k_last;
    off         = s_result_q[1:0];
    s_fault     = s_v_q && s_isload_q && load_bad(s_funct3_q, off);
    rd_nonzero  = (s_rd_q != '0);
  end

  always_comb begin
    byte_word = i_dmemRspData >> {off, 3'b000};
    half_word = i_dmemRspData >> {off[1], 4'b0000};
    load_data = i_dmemRspData;
    unique case (s_funct3_q)
      3'b000:  load_data = {{(XLEN-8){byte_word[7]}}, byte_word[7:0]};
      3'b100:  load_data = {{(XLEN-8){1'b0}}, byte_word[7:0]};
      3'b001:  load_data = {{(XLEN-16){half_word[15]}}, half_word[15:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, half_word[15:0]};
      default: load_data = i_dmemRspData;
    endcase
  end

  always_comb begin
    o_stall       = stall;
    o_retire      = s_v_q && !stall;
    o_loadFault   = s_fault;
    o_loadTimeout = timeout_q;
    o_rfRdAddr    = s_v_q ? s_rd_q : '0;
    o_rfWrEn      = s_v_q && s_regwrite_q && rd_nonzero && (s_isload_q ? rsp_take : 1'b1);
    if (!s_v_q) begin
      o_rfRdData = '0;
    end else if (s_isload_q) begin
      o_rfRdData = load_data;
    end else begin
      o_rfRdData = s_result_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      k_q          <= '0;
      timeout_q    <= 1'b0;
      s_v_q        <= 1'b0;
      s_rd_q       <= '0;
      s_regwrite_q <= 1'b0;
      s_isload_q   <= 1'b0;
      s_funct3_q   <= '0;
      s_result_q   <= '0;
    end else begin
      if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
      if (!stall) begin
        s_v_q        <= i_valid;
        s_rd_q       <= i_rd;
        s_regwrite_q <= i_regWrite;
        s_isload_q   <= i_isLoad;
        s_funct3_q   <= i_funct3;
        s_result_q   <= i_result;
        k_q          <= '0;
        // Only well-formed loads wait; faulted ones complete in their first cycle.
        if (i_valid && i_isLoad && !load_bad(i_funct3, i_result[1:0])) begin
          state_q <= StWait;
        end else begin
          state_q <= StIdle;
        end
      end else begin
        k_q <= k_q + CntW'(1);
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: expected writebacks are queued when an instruction is
// issued and compared when the stage retires it.
module tb_wb_stage;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned TO   = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid;
  logic [AW-1:0]   rd;
  logic            reg_write;
  logic            is_load;
  logic [2:0]      funct3;
  logic [XLEN-1:0] result;
  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic            stall;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [XLEN-1:0] wr_data;
  logic            retire;
  logic            load_fault;
  logic            load_timeout;

  always #5 clk = ~clk;

  wb_stage #(
    .XLEN          (XLEN),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_valid       (valid),
    .i_rd          (rd),
    .i_regWrite    (reg_write),
    .i_isLoad      (is_load),
    .i_funct3      (funct3),
    .i_result      (result),
    .i_dmemRspValid(rsp_valid),
    .i_dmemRspData (rsp_data),
    .o_stall       (stall),
    .o_rfWrEn      (wr_en),
    .o_rfRdAddr    (wr_addr),
    .o_rfRdData    (wr_data),
    .o_retire      (retire),
    .o_loadFault   (load_fault),
    .o_loadTimeout (load_timeout)
  );

  typedef struct packed {
    logic            wren;
    logic [AW-1:0]   addr;
    logic [XLEN-1:0] data;
    logic            fault;
  } wb_t;

  wb_t sb[$];
  int  tests  = 0;
  int  failed = 0;

  task automatic issue(input logic [AW-1:0] r, input logic rw, input logic ld,
                       input logic [2:0] f3, input logic [XLEN-1:0] res);
    @(negedge clk);
    valid = 1'b1; rd = r; reg_write = rw; is_load = ld; funct3 = f3; result = res;
    rsp_valid = 1'b0;
    @(posedge clk);
  endtask

  // Bubbles the input, offers a response in cycle rsp_at (-1: never) and waits for retire.
  task automatic wait_retire(input int rsp_at, input logic [XLEN-1:0] data,
                             output logic got, output int stalls, output wb_t obs);
    got = 1'b0; stalls = 0; obs = '0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      valid = 1'b0; rsp_valid = (c == rsp_at); rsp_data = data;
      #1;
      if (retire) begin
        got = 1'b1;
        obs = '{wren: wr_en, addr: wr_addr, data: wr_data, fault: load_fault};
      end else if (stall) begin
        stalls++;
      end
    end
  endtask

  // Runs one instruction end to end and compares against the queued expectation.
  task automatic run_one(input string name, input logic [AW-1:0] r, input logic rw,
                         input logic ld, input logic [2:0] f3, input logic [XLEN-1:0] res,
                         input int rsp_at, input logic [XLEN-1:0] data, input int exp_stalls,
                         input wb_t exp_wb);
    logic got;
    int   stalls;
    wb_t  obs;
    wb_t  exp;
    sb.push_back(exp_wb);
    issue(r, rw, ld, f3, res);
    wait_retire(rsp_at, data, got, stalls, obs);
    exp = sb.pop_front();
    tests++;
    if (!got || obs !== exp) begin
      failed++;
      $display("FAIL %s: got retire=%0b wren=%0b addr=%0d data=%h fault=%0b, want wren=%0b addr=%0d data=%h fault=%0b",
               name, got, obs.wren, obs.addr, obs.data, obs.fault,
               exp.wren, exp.addr, exp.data, exp.fault);
    end
    tests++;
    if (stalls !== exp_stalls) begin
      failed++;
      $display("FAIL %s_stalls: got %0d, want %0d", name, stalls, exp_stalls);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; rd = 5'd3; reg_write = 1'b1; is_load = 1'b0;
    funct3 = 3'b000; result = 32'hDEAD_BEEF; rsp_valid = 1'b1; rsp_data = '1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    tests++;
    if ({stall, wr_en, wr_addr, wr_data, retire, load_fault, load_timeout} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: got stall=%0b wren=%0b addr=%0d data=%h retire=%0b fault=%0b to=%0b, want all 0",
               stall, wr_en, wr_addr, wr_data, retire, load_fault, load_timeout);
    end
    rst = 1'b0; valid = 1'b0; rsp_valid = 1'b0;
  endtask

  task automatic test_alu();
    run_one("alu_rd5", 5'd5, 1'b1, 1'b0, 3'b000, 32'h1234_5678, -1, '0, 0,
            '{wren: 1'b1, addr: 5'd5, data: 32'h1234_5678, fault: 1'b0});
    // Stray response during a non-load must not disturb the data.
    run_one("alu_rd0", 5'd0, 1'b1, 1'b0, 3'b000, 32'h0000_00AA, 0, 32'hFFFF_FFFF, 0,
            '{wren: 1'b0, addr: 5'd0, data: 32'h0000_00AA, fault: 1'b0});
    run_one("alu_norw", 5'd6, 1'b0, 1'b0, 3'b000, 32'h0BAD_F00D, -1, '0, 0,
            '{wren: 1'b0, addr: 5'd6, data: 32'h0BAD_F00D, fault: 1'b0});
  endtask

  task automatic test_byte_loads();
    run_one("lb_off3", 5'd10, 1'b1, 1'b1, 3'b000, 32'h0000_1003, 2, 32'h80AA_BBCC, 2,
            '{wren: 1'b1, addr: 5'd10, data: 32'hFFFF_FF80, fault: 1'b0});
    run_one("lbu_off3", 5'd11, 1'b1, 1'b1, 3'b100, 32'h0000_1003, 2, 32'h80AA_BBCC, 2,
            '{wren: 1'b1, addr: 5'd11, data: 32'h0000_0080, fault: 1'b0});
    run_one("lb_off1", 5'd12, 1'b1, 1'b1, 3'b000, 32'h0000_2001, 0, 32'h1122_7F44, 0,
            '{wren: 1'b1, addr: 5'd12, data: 32'h0000_007F, fault: 1'b0});
  endtask

  task automatic test_half_loads();
    run_one("lh_off2", 5'd13, 1'b1, 1'b1, 3'b001, 32'h0000_3002, 0, 32'h8001_7FFF, 0,
            '{wren: 1'b1, addr: 5'd13, data: 32'hFFFF_8001, fault: 1'b0});
    run_one("lhu_off0", 5'd14, 1'b1, 1'b1, 3'b101, 32'h0000_3000, 1, 32'h8001_F00F, 1,
            '{wren: 1'b1, addr: 5'd14, data: 32'h0000_F00F, fault: 1'b0});
    // Misaligned: a stray response in the same cycle is ignored.
    run_one("lhu_fault", 5'd15, 1'b1, 1'b1, 3'b101, 32'h0000_3001, 0, 32'h1234_5678, 0,
            '{wren: 1'b0, addr: 5'd15, data: 32'h0000_5678, fault: 1'b1});
    @(negedge clk); #1;
    tests++;
    if (load_fault !== 1'b0) begin
      failed++;
      $display("FAIL fault_pulse: got %0b, want 0", load_fault);
    end
    run_one("f3_illegal", 5'd16, 1'b1, 1'b1, 3'b011, 32'h0000_3000, -1, 32'h0, 0,
            '{wren: 1'b0, addr: 5'd16, data: 32'h0, fault: 1'b1});
    run_one("lw_misal", 5'd17, 1'b1, 1'b1, 3'b010, 32'h0000_3002, -1, 32'h0, 0,
            '{wren: 1'b0, addr: 5'd17, data: 32'h0, fault: 1'b1});
  endtask

  task automatic test_rsp_at_timeout();
    run_one("lw_last_cycle", 5'd18, 1'b1, 1'b1, 3'b010, 32'h0000_4000, TO - 1,
            32'hCAFE_BABE, TO - 1,
            '{wren: 1'b1, addr: 5'd18, data: 32'hCAFE_BABE, fault: 1'b0});
    @(negedge clk); #1;
    tests++;
    if (load_timeout !== 1'b0) begin
      failed++;
      $display("FAIL no_timeout_flag: got %0b, want 0", load_timeout);
    end
  endtask

  task automatic test_timeout();
    run_one("lw_timeout", 5'd19, 1'b1, 1'b1, 3'b010, 32'h0000_4004, -1, 32'h0, TO - 1,
            '{wren: 1'b0, addr: 5'd19, data: 32'h0, fault: 1'b0});
    @(negedge clk); #1;
    tests++;
    if (load_timeout !== 1'b1) begin
      failed++;
      $display("FAIL timeout_flag: got %0b, want 1", load_timeout);
    end
    run_one("alu_after_to", 5'd20, 1'b1, 1'b0, 3'b000, 32'h5555_AAAA, -1, '0, 0,
            '{wren: 1'b1, addr: 5'd20, data: 32'h5555_AAAA, fault: 1'b0});
    tests++;
    if (load_timeout !== 1'b1) begin
      failed++;
      $display("FAIL timeout_sticky: got %0b, want 1", load_timeout);
    end
  endtask

  task automatic test_reset_mid_wait();
    issue(5'd21, 1'b1, 1'b1, 3'b010, 32'h0000_5000);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      valid = 1'b0; rsp_valid = 1'b0; #1;
      tests++;
      if (stall !== 1'b1) begin
        failed++;
        $display("FAIL wait_stall_%0d: got %0b, want 1", c, stall);
      end
    end
    @(negedge clk);
    rst = 1'b1; #1;
    tests++;
    if (retire !== 1'b0 || wr_en !== 1'b0) begin
      failed++;
      $display("FAIL rst_cycle: got retire=%0b wren=%0b, want 0 0", retire, wr_en);
    end
    @(negedge clk);
    rst = 1'b0; #1;
    tests++;
    if ({retire, wr_en, stall, load_timeout} !== 4'b0000) begin
      failed++;
      $display("FAIL after_rst: got retire=%0b wren=%0b stall=%0b to=%0b, want all 0",
               retire, wr_en, stall, load_timeout);
    end
    run_one("lw_after_rst", 5'd22, 1'b1, 1'b1, 3'b010, 32'h0000_5004, -1, 32'h0, TO - 1,
            '{wren: 1'b0, addr: 5'd22, data: 32'h0, fault: 1'b0});
  endtask

  task automatic test_back_to_back();
    wb_t exp;
    sb.push_back('{wren: 1'b1, addr: 5'd7, data: 32'h0000_0033, fault: 1'b0});
    sb.push_back('{wren: 1'b1, addr: 5'd8, data: 32'h0000_CAFE, fault: 1'b0});
    issue(5'd7, 1'b1, 1'b1, 3'b100, 32'h0000_6001);
    // Second load is presented in the same cycle the first one's response lands.
    @(negedge clk);
    valid = 1'b1; rd = 5'd8; reg_write = 1'b1; is_load = 1'b1; funct3 = 3'b101;
    result = 32'h0000_6002; rsp_valid = 1'b1; rsp_data = 32'h1122_3344; #1;
    exp = sb.pop_front();
    tests++;
    if (!retire || stall || {wr_en, wr_addr, wr_data} !== {exp.wren, exp.addr, exp.data}) begin
      failed++;
      $display("FAIL b2b_first: got retire=%0b stall=%0b wren=%0b addr=%0d data=%h, want 1 0 %0b %0d %h",
               retire, stall, wr_en, wr_addr, wr_data, exp.wren, exp.addr, exp.data);
    end
    @(negedge clk);
    valid = 1'b0; rsp_valid = 1'b0; #1;
    tests++;
    if (stall !== 1'b1 || retire !== 1'b0) begin
      failed++;
      $display("FAIL b2b_second_wait: got stall=%0b retire=%0b, want 1 0", stall, retire);
    end
    @(negedge clk);
    rsp_valid = 1'b1; rsp_data = 32'hCAFE_0000; #1;
    exp = sb.pop_front();
    tests++;
    if (!retire || {wr_en, wr_addr, wr_data} !== {exp.wren, exp.addr, exp.data}) begin
      failed++;
      $display("FAIL b2b_second: got retire=%0b wren=%0b addr=%0d data=%h, want 1 %0b %0d %h",
               retire, wr_en, wr_addr, wr_data, exp.wren, exp.addr, exp.data);
    end
    @(negedge clk);
    rsp_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_byte_loads();
    test_half_loads();
    test_rsp_at_timeout();
    test_timeout();
    test_reset_mid_wait();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the register file.
- Holds the MEM/WB pipeline register and waits for data-memory load responses.
- Aligns and sign/zero-extends load data, suppresses writes to x0 and faulted loads, and drives the register file write port (write enable, rd address, rd data).
- Stalls upstream while a load response is outstanding and times out hung loads.

Parameters:
- XLEN, 32, datapath width; load alignment logic is defined for 32 only.
- ADDR_WIDTH, 5, register address width.
- TIMEOUT_CYCLES, 16, max cycles a load may wait for a response (>=2); counter width clog2(TIMEOUT_CYCLES).

Ports:
- i_clk  in  1  clock; all state updates on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_valid  in  1  MEM stage presents an instruction.
- i_rd  in  ADDR_WIDTH  destination register.
- i_regWrite  in  1  instruction writes rd.
- i_isLoad  in  1  instruction is a load.
- i_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- i_result  in  XLEN  ALU result (load address for loads; bits [1:0] are the byte offset).
- i_dmemRspValid  in  1  load response data valid this cycle.
- i_dmemRspData  in  XLEN  raw 32-bit word from data memory.
- o_stall  out  1  upstream must hold its inputs; stage register does not load.
- o_rfWrEn  out  1  register file write enable.
- o_rfRdAddr  out  ADDR_WIDTH  register file write address.
- o_rfRdData  out  XLEN  register file write data.
- o_retire  out  1  one-cycle pulse when the held instruction completes.
- o_loadFault  out  1  one-cycle pulse: misaligned load or illegal funct3.
- o_loadTimeout  out  1  sticky; set on a load timeout, cleared only by reset.

Behaviour:
- Reset: stage register valid (S.v)=0, FSM=IDLE, wait counter=0, o_loadTimeout=0. All outputs combinationally 0 while S.v=0.
- Stage register: captures {i_valid, i_rd, i_regWrite, i_isLoad, i_funct3, i_result} at each edge where o_stall=0. If o_stall=0 and i_valid=0, S.v becomes 0.
- FSM states:
  - IDLE: S empty or S holds a non-load.
  - WAIT: S holds a well-formed load; counter k counts cycles in S, starting at 0.
  - Transitions: entering a good load -> WAIT with k=0. WAIT->IDLE on response, on timeout, or when the next captured instruction is not a load.
- Non-load in S: completes in its cycle; o_retire=1; o_rfWrEn = S.regWrite && rd!=0; o_rfRdData = S.result; o_stall=0.
- Load fault, checked in S's first cycle:
  - Fault conditions: LH/LHU with offset[0]=1, LW with offset!=0, or funct3 in {011,110,111}.
  - Response: completes immediately with o_loadFault=1, o_retire=1, o_rfWrEn=0, o_stall=0.
  - Data memory issues no request for faulted loads; any stray response is ignored.
- Good load, cycle k:
  - i_dmemRspValid=1 -> complete: o_rfWrEn = regWrite && rd!=0, o_rfRdData = extracted data, o_retire=1, o_stall=0.
  - No response and k<TIMEOUT_CYCLES-1 -> o_stall=1, k increments.
  - No response and k==TIMEOUT_CYCLES-1 -> timeout: o_rfWrEn=0, o_retire=1, o_stall=0, o_loadTimeout set next edge.
  - A response in the timeout cycle wins; it completes normally and is not a timeout.
- Extraction:
  - LB/LBU: byte at offset*8, sign/zero-extended.
  - LH/LHU: half at offset[1]*16, sign/zero-extended.
  - LW: the full word.
- i_dmemRspValid outside a good load in S is ignored.
- o_rfRdAddr always equals S.rd.
- o_rfWrEn is asserted at most once per instruction.
- Reset mid-WAIT drops the load: no write, no retire.
- Back-to-back loads each get their own k, starting at 0.

Test Plan:
- Reset, then ALU op rd=5 result=0x1234_5678 -> next cycle o_rfWrEn=1, addr=5, data=0x12345678, o_retire=1.
- ALU op with rd=0 -> o_rfWrEn=0, o_retire=1.
- LB, offset=3, response 0x80AA_BBCC arriving 2 cycles after entry -> o_stall=1 for 2 cycles, then write 0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- LH offset=2 with response 0x8001_7FFF in the entry cycle -> no stall, data 0xFFFF_8001. LHU offset=1 -> o_loadFault pulse, no write, no stall.
- LW with no response, TIMEOUT_CYCLES=16 -> o_stall high for 15 cycles, retire with no write in the 16th, o_loadTimeout=1 and held. Repeat with the response in the 16th cycle -> normal write, flag stays 0.
- Reset asserted during the 3rd WAIT cycle -> no write or retire. The next load after reset starts its timeout count at 0.
